// File: rtl/jtframe_db15_pkg.sv
// Shared types and sizing helpers for the DB15 joystick serial responder.
package jtframe_db15_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int DEF_PLAYER_W  = 12;
    localparam int DEF_FRAME_LEN = 2 * DEF_PLAYER_W;

    function automatic int frame_len(input int player_w);
        return 2 * player_w;
    endfunction

    // Counter must hold the full frame length, not just length-1.
    function automatic int cnt_width(input int player_w);
        return $clog2(2 * player_w + 1);
    endfunction

endpackage

// File: rtl/jtframe_sync2.sv
// Two-flop synchroniser for one asynchronous level, with selectable reset value.
module jtframe_sync2 #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
        end
    end

    assign dout = sync_reg;

endmodule

// File: rtl/jtframe_db15_tx.sv
// DB15 adapter emulation: parallel-load both player words on joy_load low,
// then shift them out LSB first on each rising edge of joy_clk.
module jtframe_db15_tx
    import jtframe_db15_pkg::*;
#(
    parameter int PLAYER_W   = DEF_PLAYER_W,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                joy_clk,
    input  logic                joy_load,
    output logic                joy_data,
    input  logic [PLAYER_W-1:0] joystick1,
    input  logic [PLAYER_W-1:0] joystick2,
    output logic                frame_done,
    output logic                overrun
);

    localparam int FRAME_W = frame_len(PLAYER_W);
    localparam int CNT_W   = cnt_width(PLAYER_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic               clk_sync;
    logic               load_sync;
    logic               clk_hist_reg;
    logic               clk_rise;
    logic               load_act;
    logic [FRAME_W-1:0] frame_vec;

    state_t             state_reg, state_next;
    logic [FRAME_W-1:0] sr_reg, sr_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               done_reg, done_next;
    logic               ovr_reg, ovr_next;

    // Reset values match the idle link levels so reset never looks like a load or edge.
    jtframe_sync2 #(.RST_VAL(1'b0)) u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (joy_clk),
        .dout  (clk_sync)
    );

    jtframe_sync2 #(.RST_VAL(1'b1)) u_sync_load (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (joy_load),
        .dout  (load_sync)
    );

    assign clk_rise  = clk_sync & ~clk_hist_reg;
    assign load_act  = ~load_sync;
    assign frame_vec = {joystick2, joystick1} ^ {FRAME_W{ACTIVE_LOW}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_hist_reg <= 1'b0;
            state_reg    <= ST_IDLE;
            sr_reg       <= {FRAME_W{IDLE_LEVEL}};
            cnt_reg      <= '0;
            done_reg     <= 1'b0;
            ovr_reg      <= 1'b0;
        end else begin
            clk_hist_reg <= clk_sync;
            state_reg    <= state_next;
            sr_reg       <= sr_next;
            cnt_reg      <= cnt_next;
            done_reg     <= done_next;
            ovr_reg      <= ovr_next;
        end
    end

    // A load wins over everything, including a clock edge in the same cycle.
    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        ovr_next   = ovr_reg;
        if (load_act) begin
            state_next = ST_LOAD;
            sr_next    = frame_vec;
            cnt_next   = CNT_FULL;
            ovr_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: state_next = ST_IDLE;
                ST_LOAD: state_next = ST_SHIFT;
                ST_SHIFT: begin
                    if (clk_rise) begin
                        sr_next  = {IDLE_LEVEL, sr_reg[FRAME_W-1:1]};
                        cnt_next = cnt_reg - CNT_ONE;
                        if (cnt_reg == CNT_ONE) begin
                            done_next  = 1'b1;
                            state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (clk_rise) ovr_next = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        joy_data = IDLE_LEVEL;
        if (state_reg == ST_LOAD || state_reg == ST_SHIFT) joy_data = sr_reg[0];
    end

    assign frame_done = done_reg;
    assign overrun    = ovr_reg;

endmodule

// File: tb/tb_jtframe_db15_tx.sv
// Bench for jtframe_db15_tx: constant frame table, directed corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_jtframe_db15_tx;

    localparam int PW = 12;
    localparam int FL = 2 * PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          joy_clk = 1'b0;
    logic          joy_load = 1'b1;
    logic [PW-1:0] joystick1 = '0;
    logic [PW-1:0] joystick2 = '0;
    logic          data1, done1, ovr1;
    logic          data0, done0, ovr0;

    always #5 clk = ~clk;

    jtframe_db15_tx #(.PLAYER_W(PW), .ACTIVE_LOW(1'b1), .IDLE_LEVEL(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (data1),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (done1),
        .overrun    (ovr1)
    );

    jtframe_db15_tx #(.PLAYER_W(PW), .ACTIVE_LOW(1'b0), .IDLE_LEVEL(1'b1)) dut_ah (
        .clk        (clk),
        .rst_n      (rst_n),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (data0),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .frame_done (done0),
        .overrun    (ovr0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int fd1 = 0;
    int fd0 = 0;

    always @(negedge clk) begin
        if (done1) fd1++;
        if (done0) fd0++;
    end

    // Reference model: the frame as captured at load, bits already sent, frame_done count.
    logic [FL-1:0] m_frame = '0;
    int            m_mode  = 0;   // 0 idle, 1 frame in flight, 2 all bits sent
    int            m_idx   = 0;
    int            m_fd    = 0;
    bit            m_ovr   = 1'b0;

    function automatic logic m_bit(input bit al);
        if (m_mode == 1) return m_frame[m_idx] ^ al;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".data_al1"}, int'(data1), int'(m_bit(1'b1)));
        chk({tag, ".data_al0"}, int'(data0), int'(m_bit(1'b0)));
        chk({tag, ".ovr_al1"}, int'(ovr1), int'(m_ovr));
        chk({tag, ".ovr_al0"}, int'(ovr0), int'(m_ovr));
        chk({tag, ".fd_al1"}, fd1, m_fd);
        chk({tag, ".fd_al0"}, fd0, m_fd);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load();
        joy_load = 1'b0;
        m_frame  = {joystick2, joystick1};
        m_mode   = 1;
        m_idx    = 0;
        m_ovr    = 1'b0;
        wait_clks(6);
        chk_all("load");
        joy_load = 1'b1;
        wait_clks(6);
        chk_all("post_load");
        $display("txn load j1=%03h j2=%03h data=%0b/%0b", joystick1, joystick2, data1, data0);
    endtask

    task automatic do_edge();
        joy_clk = 1'b1;
        if (m_mode == 1) begin
            m_idx++;
            if (m_idx == FL) begin
                m_mode = 2;
                m_fd++;
            end
        end else if (m_mode == 2) begin
            m_ovr = 1'b1;
        end
        wait_clks(6);
        chk_all("edge");
        $display("txn edge idx=%0d data=%0b/%0b ovr=%0b fd=%0d", m_idx, data1, data0, ovr1, fd1);
        joy_clk = 1'b0;
        wait_clks(6);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        wait_clks(cycles);
        chk("rst.data_al1", int'(data1), 1);
        chk("rst.data_al0", int'(data0), 1);
        chk("rst.done", int'(done1 | done0), 0);
        chk("rst.ovr", int'(ovr1 | ovr0), 0);
        m_mode = 0;
        m_idx  = 0;
        m_ovr  = 1'b0;
        rst_n  = 1'b1;
        wait_clks(4);
        chk_all("post_rst");
        $display("txn reset");
    endtask

    typedef struct {
        logic [PW-1:0] j1;
        logic [PW-1:0] j2;
        logic [FL-1:0] e1;   // bit k = k-th bit on the wire, ACTIVE_LOW=1
        logic [FL-1:0] e0;   // same, ACTIVE_LOW=0
    } vec_t;

    vec_t tbl [4];

    initial begin
        int fd_before;

        tbl[0] = '{12'h001, 12'h800, 24'h7FFFFE, 24'h800001};
        tbl[1] = '{12'hFFF, 12'h000, 24'hFFF000, 24'h000FFF};
        tbl[2] = '{12'h000, 12'hA5A, 24'h5A5FFF, 24'hA5A000};
        tbl[3] = '{12'h123, 12'h456, 24'hBA9EDC, 24'h456123};

        wait_clks(3);
        do_reset(2);

        // Full frames from the constant table, each followed by one extra edge.
        for (int t = 0; t < 4; t++) begin
            joystick1 = tbl[t].j1;
            joystick2 = tbl[t].j2;
            do_load();
            chk("tbl.bit0_al1", int'(data1), int'(tbl[t].e1[0]));
            chk("tbl.bit0_al0", int'(data0), int'(tbl[t].e0[0]));
            for (int k = 1; k <= FL; k++) begin
                do_edge();
                if (k < FL) begin
                    chk("tbl.bit_al1", int'(data1), int'(tbl[t].e1[k]));
                    chk("tbl.bit_al0", int'(data0), int'(tbl[t].e0[k]));
                end else begin
                    chk("tbl.idle_after", int'(data1 & data0), 1);
                end
            end
            do_edge();
            chk("tbl.overrun", int'(ovr1), 1);
            chk("tbl.overrun_data", int'(data1), 1);
        end

        // Mid-frame reload aborts the frame without frame_done.
        joystick1 = 12'h3C5;
        joystick2 = 12'h0F0;
        do_load();
        fd_before = fd1;
        for (int k = 0; k < 10; k++) do_edge();
        joystick1 = 12'hFFF;
        do_load();
        chk("reload.bit0", int'(data1), 0);
        chk("reload.no_fd", fd1, fd_before);
        for (int k = 0; k < FL; k++) do_edge();
        chk("reload.fd_once", fd1, fd_before + 1);

        // Button changes during shifting do not reach the frame in flight.
        joystick1 = 12'h000;
        joystick2 = 12'h5A5;
        do_load();
        for (int k = 0; k < 5; k++) do_edge();
        joystick1 = 12'hFFF;
        for (int k = 5; k < FL; k++) begin
            do_edge();
            if (k + 1 < PW) chk("hold.j1_bit", int'(data1), 1);
        end

        // Reset mid-frame, then edges without a load stay idle.
        joystick1 = 12'h0AA;
        joystick2 = 12'h055;
        do_load();
        for (int k = 0; k < 7; k++) do_edge();
        fd_before = fd1;
        do_reset(2);
        for (int k = 0; k < 3; k++) do_edge();
        chk("rst_idle.data", int'(data1), 1);
        chk("rst_idle.ovr", int'(ovr1), 0);
        chk("rst_idle.no_fd", fd1, fd_before);

        // Randomized frames with reloads and button churn.
        for (int r = 0; r < 8; r++) begin
            int n_edges;
            joystick1 = PW'($urandom);
            joystick2 = PW'($urandom);
            do_load();
            n_edges = $urandom_range(1, FL + 3);
            for (int k = 0; k < n_edges; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    joystick1 = PW'($urandom);
                    joystick2 = PW'($urandom);
                end
                if (m_mode == 1 && $urandom_range(0, 15) == 0) do_load();
                do_edge();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtframe_db15_tx.md
Name: jtframe_db15_tx

Overview:
- Responder end of the DB15 joystick serial link, emulating the external adapter's parallel-in/serial-out shift chain.
- Samples JOY_LOAD and JOY_CLK driven by the host-side reader and shifts both players' button words out on JOY_DATA.
- Used as the bench model for the DB15 reader and on boards that act as a DB15 adapter.
- Clocked by the system clock. Link inputs are asynchronous to it and are synchronised internally.

Parameters:
- PLAYER_W, 12: bits per player word; frame length is 2*PLAYER_W.
- ACTIVE_LOW, 1: 1 means a pressed button is driven as 0 on the wire.
- IDLE_LEVEL, 1: JOY_DATA level outside a frame and after the last bit.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- joy_clk, input, 1: shift clock from the reader; asynchronous.
- joy_load, input, 1: parallel-load strobe from the reader, active low; asynchronous.
- joy_data, output, 1: serial data to the reader.
- joystick1, input, PLAYER_W: player 1 buttons, active high; bit 0 = first bit sent within the word.
- joystick2, input, PLAYER_W: player 2 buttons, active high.
- frame_done, output, 1: one-cycle pulse when the last bit of a frame has been shifted out.
- overrun, output, 1: sticky flag; joy_clk rose with no bits left. Cleared by the next load.

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: joy_data=IDLE_LEVEL, frame_done=0, overrun=0, state=IDLE, shift register all IDLE_LEVEL, bit count 0.
- Synchronisation:
  - joy_clk and joy_load each pass through a 2-flop synchroniser plus one history flop.
  - Rising edge of joy_clk = sync high AND history low.
  - Load active = synced joy_load low.
- Word mapping:
  - Frame vector = {joystick2, joystick1}.
  - Each bit is inverted when ACTIVE_LOW=1.
  - Transmission order: joystick1 bit 0 first, through joystick2 bit PLAYER_W-1 last.
- State machine, states IDLE, LOAD, SHIFT, DONE:
  - IDLE: joy_data=IDLE_LEVEL. Load active -> LOAD.
  - LOAD:
    - Every cycle while load is active, the shift register copies the frame vector (transparent, like a 74HC165 with PL low).
    - joy_data = bit 0 of the frame vector; bit count = 2*PLAYER_W.
    - Load released -> SHIFT.
  - SHIFT:
    - On each joy_clk rising edge, the register shifts right, filling with IDLE_LEVEL; the count decrements.
    - joy_data follows register bit 0.
    - When the count reaches 0 after a shift: frame_done pulses for one cycle -> DONE.
  - DONE:
    - joy_data=IDLE_LEVEL.
    - A further joy_clk rising edge sets overrun, with no data change.
    - Load active -> LOAD.
- Load priority: load active in any state forces LOAD. A clock edge in the same cycle is ignored. A load in mid-frame therefore aborts the frame without frame_done and clears overrun.
- Timing:
  - joy_data changes 3 clk cycles after a joy_clk rising edge at the pin (2 sync + 1 register).
  - The reader must sample at least 4 clk cycles after its rising edge.
  - joy_clk high and low phases must each be at least 3 clk cycles; shorter pulses may be missed, and that is not flagged.
- Button changes during SHIFT do not alter the frame in flight. They are captured at the next load.
- Reset asserted mid-frame returns immediately to the reset values. Shifting resumes only after a new load.

Decomposition:
- Package jtframe_db15_pkg holds:
  - state enum type (IDLE, LOAD, SHIFT, DONE);
  - localparam for frame length;
  - bit-count width function ($clog2(2*PLAYER_W+1)).
- One sub-module, jtframe_sync2: 2-flop synchroniser with async active-low reset and parameterised reset value. It is instantiated for joy_clk (reset 0) and joy_load (reset 1).
- The reader's reset state must not produce a spurious load or clock edge.

Test Plan:
1. Normal frame: joystick1=12'h001, joystick2=12'h800, ACTIVE_LOW=1, load pulse then 24 clocks -> serial stream 0, then 22×1, then 0; frame_done pulses once after the 24th edge; joy_data returns to 1.
2. Extra clock: after scenario 1, one more joy_clk edge -> overrun=1, joy_data stays 1. The next load clears overrun.
3. Mid-frame reload: load after 10 edges with joystick1=12'hFFF -> bits restart at joystick1 bit 0 (driven 0); no frame_done for the aborted frame.
4. Inputs change during shift: joystick1 toggles 12'h000->12'hFFF after edge 5 -> the remaining bits still reflect 12'h000 until the next load.
5. ACTIVE_LOW=0, joystick2=12'hA5A -> the last 12 bits are 0,1,0,1,1,0,1,0,0,1,0,1 (LSB first).
6. Reset mid-frame: rst_n low for 2 cycles after edge 7 -> joy_data=1, frame_done stays 0; later joy_clk edges without a load leave joy_data=1 and state IDLE.
